// File: rtl/freq_light_decider_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : freq_light_pkg
//  Description : Shared types, constants and the code-to-light pattern helper
//                for the frequency light decision block.
//  Contents    : state_t    - decision FSM states (IDLE, SHOW, STALE)
//                CODE_NONE  - classifier code meaning "no frequency read"
//                pattern()  - maps a classifier code to a light pattern
//  Revision    : 1.0 - initial release
// ============================================================================
package freq_light_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    STALE = 2'd2
  } state_t;

  localparam int unsigned CODE_NONE  = 0;

  // Widest pattern the helper can build; callers cast down to their width.
  localparam int unsigned MAX_LIGHTS = 32;

  // Code 0 lights everything, 1..num_lights is one-hot at bit code-1,
  // anything else (out-of-range classifier output) leaves all lights off.
  function automatic logic [MAX_LIGHTS-1:0] pattern(input int unsigned code,
                                                    input int unsigned num_lights);
    logic [MAX_LIGHTS-1:0] p;
    p = '0;
    if (code == CODE_NONE) begin
      if (num_lights >= MAX_LIGHTS) begin
        p = {MAX_LIGHTS{1'b1}};
      end else begin
        p = (MAX_LIGHTS'(1) << num_lights) - MAX_LIGHTS'(1);
      end
    end else if (code <= num_lights) begin
      p = MAX_LIGHTS'(1) << (code - 1);
    end
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/freq_light_decider_if.sv
`default_nettype none
// ============================================================================
//  Module      : freq_light_decider_if
//  Description : Classifier-result input and light-output bundle of the
//                frequency light decision block.
//  Signals     : answer_in    - classifier code
//                answer_valid - answer_in is sampled while high
//                light_out    - registered light pattern
//                shown_code   - last committed code
//                locked       - a code is being displayed steadily
//                stale        - classifier updates lost, lights blink
//  Modports    : master - classifier side (drives answers, sees display)
//                slave  - decision block side
//  Revision    : 1.0 - initial release
// ============================================================================
interface freq_light_decider_if #(
  parameter int unsigned NUM_LIGHTS = 4,
  parameter int unsigned CODE_W     = 3
) ();

  logic [CODE_W-1:0]     answer_in;
  logic                  answer_valid;
  logic [NUM_LIGHTS-1:0] light_out;
  logic [CODE_W-1:0]     shown_code;
  logic                  locked;
  logic                  stale;

  modport master (
    output answer_in, answer_valid,
    input  light_out, shown_code, locked, stale
  );

  modport slave (
    input  answer_in, answer_valid,
    output light_out, shown_code, locked, stale
  );

endinterface
`default_nettype wire

// File: rtl/freq_light_decider_confirm.sv
`default_nettype none
// ============================================================================
//  Module      : decision_confirm
//  Description : Debounce filter for classifier codes. Tracks the current
//                candidate code and how many consecutive valid samples have
//                matched it (saturating at CONFIRM_COUNT).
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                sample_valid  - a code is presented this cycle
//                sample_code   - the presented code
//                clear         - zero the match count (only used on cycles
//                                without a sample)
//                confirmed     - candidate has CONFIRM_COUNT matches
//                                including this cycle's sample
//                cand_code     - candidate code including this cycle's sample
//  Revision    : 1.0 - initial release
// ============================================================================
module decision_confirm #(
  parameter int unsigned CODE_W        = 3,
  parameter int unsigned CONFIRM_COUNT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [CODE_W-1:0] sample_code,
  input  logic              clear,
  output logic              confirmed,
  output logic [CODE_W-1:0] cand_code
);

  localparam int unsigned    CNT_W   = $clog2(CONFIRM_COUNT) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CONFIRM_COUNT);

  logic [CODE_W-1:0] cand;
  logic [CODE_W-1:0] cand_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_smp;
  logic [CNT_W-1:0]  cnt_nxt;

  // Sample path kept separate from the clear so that 'confirmed' never
  // depends on the top's stale-entry decision.
  always_comb begin
    cand_nxt = cand;
    cnt_smp  = cnt;
    if (sample_valid) begin
      if (sample_code == cand) begin
        if (cnt != CNT_MAX) begin
          cnt_smp = cnt + 1'b1;
        end
      end else begin
        cand_nxt = sample_code;
        cnt_smp  = CNT_W'(1);
      end
    end
  end

  assign cnt_nxt   = clear ? '0 : cnt_smp;
  assign confirmed = (cnt_smp == CNT_MAX);
  assign cand_code = cand_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cand <= '0;
      cnt  <= '0;
    end else begin
      cand <= cand_nxt;
      cnt  <= cnt_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/freq_light_decider.sv
`default_nettype none
// ============================================================================
//  Module      : freq_light_decider
//  Description : Decides the indicator-light pattern from debounced
//                frequency classifier results. Enforces a minimum hold time
//                between display changes and blinks all lights when the
//                classifier stops reporting.
//  Ports       : clk  - system clock, rising edge
//                rst  - synchronous reset, active high
//                bus  - freq_light_decider_if.slave (answer in, display out)
//  Revision    : 1.0 - initial release
// ============================================================================
module freq_light_decider
  import freq_light_pkg::*;
#(
  parameter int unsigned NUM_LIGHTS     = 4,
  parameter int unsigned CODE_W         = 3,
  parameter int unsigned CONFIRM_COUNT  = 4,
  parameter int unsigned HOLD_CYCLES    = 1_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned BLINK_HALF     = 25_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  freq_light_decider_if.slave  bus
);

  localparam int unsigned HOLD_W  = $clog2(HOLD_CYCLES) + 1;
  localparam int unsigned TO_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int unsigned BLINK_W = $clog2(BLINK_HALF) + 1;

  localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [TO_W-1:0]    TO_MAX    = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_HALF - 1);

  typedef logic [NUM_LIGHTS-1:0] lights_t;

  state_t             state, state_n;
  logic [CODE_W-1:0]  shown, shown_n;
  lights_t            light, light_n;
  logic [HOLD_W-1:0]  hold, hold_n;
  logic [TO_W-1:0]    tcnt, tcnt_n;
  logic [BLINK_W-1:0] bcnt, bcnt_n;
  logic               blink_on, blink_on_n;
  logic               commit;
  logic               clear_cnt;
  logic               confirmed;
  logic [CODE_W-1:0]  cand;

  decision_confirm #(
    .CODE_W        (CODE_W),
    .CONFIRM_COUNT (CONFIRM_COUNT)
  ) u_confirm (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (bus.answer_valid),
    .sample_code  (bus.answer_in),
    .clear        (clear_cnt),
    .confirmed    (confirmed),
    .cand_code    (cand)
  );

  always_comb begin
    state_n    = state;
    shown_n    = shown;
    light_n    = light;
    blink_on_n = blink_on;
    bcnt_n     = bcnt;
    clear_cnt  = 1'b0;
    hold_n     = (hold != '0) ? hold - 1'b1 : hold;
    // Saturates so a long silence in IDLE/STALE never wraps back to zero.
    tcnt_n     = bus.answer_valid ? '0 : ((tcnt != TO_MAX) ? tcnt + 1'b1 : tcnt);

    // Re-committing the shown code is only meaningful when leaving STALE.
    commit = confirmed && ((cand != shown) || (state != SHOW)) && (hold == '0);

    if (commit) begin
      state_n = SHOW;
      shown_n = cand;
      light_n = lights_t'(pattern(32'(cand), NUM_LIGHTS));
      hold_n  = HOLD_LOAD;
    end else begin
      case (state)
        SHOW: begin
          // A sample on the timeout edge keeps the display alive.
          if (!bus.answer_valid && (tcnt == TO_MAX)) begin
            state_n    = STALE;
            clear_cnt  = 1'b1;
            bcnt_n     = '0;
            blink_on_n = 1'b1;
            light_n    = '1;
          end
        end
        STALE: begin
          if (bcnt == BLINK_MAX) begin
            bcnt_n     = '0;
            blink_on_n = !blink_on;
            light_n    = blink_on ? lights_t'('0) : lights_t'('1);
          end else begin
            bcnt_n = bcnt + 1'b1;
          end
        end
        default: begin
          light_n = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shown    <= '0;
      light    <= '0;
      hold     <= '0;
      tcnt     <= '0;
      bcnt     <= '0;
      blink_on <= 1'b0;
    end else begin
      state    <= state_n;
      shown    <= shown_n;
      light    <= light_n;
      hold     <= hold_n;
      tcnt     <= tcnt_n;
      bcnt     <= bcnt_n;
      blink_on <= blink_on_n;
    end
  end

  assign bus.light_out  = light;
  assign bus.shown_code = shown;
  assign bus.locked     = (state == SHOW);
  assign bus.stale      = (state == STALE);

endmodule
`default_nettype wire

// File: tb/tb_freq_light_decider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_freq_light_decider
//  Description : Self-checking bench for freq_light_decider. Every cycle is
//                compared against a cycle-count based reference model; a
//                vector table and hand sequences pin down specific cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_freq_light_decider;

  localparam int NL = 4;
  localparam int CW = 3;
  localparam int CC = 3;
  localparam int HOLD = 8;
  localparam int TO = 50;
  localparam int BH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  freq_light_decider_if #(.NUM_LIGHTS(NL), .CODE_W(CW)) bus ();

  freq_light_decider #(
    .NUM_LIGHTS     (NL),
    .CODE_W         (CW),
    .CONFIRM_COUNT  (CC),
    .HOLD_CYCLES    (HOLD),
    .TIMEOUT_CYCLES (TO),
    .BLINK_HALF     (BH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: history expressed as cycle stamps and a run length.
  int m_code, m_len, m_shown, m_mode, m_lc, m_lv, m_ss;
  bit m_has_lc;

  typedef struct {
    bit         r;
    bit         v;
    logic [2:0] code;
    logic [8:0] exp;
  } vec_t;
  vec_t vecs[$];

  function automatic logic [3:0] ref_pat(input int c);
    if (c == 0) return 4'hF;
    else if (c >= 1 && c <= NL) return 4'(1 << (c - 1));
    else return 4'h0;
  endfunction

  function automatic logic [8:0] ref_out();
    logic [3:0] l;
    case (m_mode)
      1:       l = ref_pat(m_shown);
      2:       l = ((((cyc - m_ss) / BH) % 2) == 0) ? 4'hF : 4'h0;
      default: l = 4'h0;
    endcase
    return {l, 3'(m_shown), (m_mode == 1), (m_mode == 2)};
  endfunction

  function automatic void model_edge(input bit r, input bit v, input int code);
    bit cm;
    if (r) begin
      m_code = 0; m_len = 0; m_shown = 0; m_mode = 0;
      m_has_lc = 1'b0; m_lc = 0; m_lv = cyc; m_ss = 0;
      return;
    end
    if (v) begin
      if (code == m_code) m_len++;
      else begin
        m_code = code;
        m_len  = 1;
      end
      m_lv = cyc;
    end
    cm = (m_len >= CC) && ((m_code != m_shown) || (m_mode != 1)) &&
         (!m_has_lc || (cyc - m_lc >= HOLD));
    if (cm) begin
      m_shown = m_code; m_mode = 1; m_lc = cyc; m_has_lc = 1'b1;
    end else if (m_mode == 1 && !v && (cyc - m_lv >= TO)) begin
      m_mode = 2; m_ss = cyc; m_len = 0;
    end
  endfunction

  function automatic logic [8:0] outs();
    return {bus.light_out, bus.shown_code, bus.locked, bus.stale};
  endfunction

  function automatic void check(input string name, input int idx,
                                input logic [8:0] act, input logic [8:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s #%0d: got light=%b code=%0d locked=%b stale=%b, want light=%b code=%0d locked=%b stale=%b",
               name, idx, act[8:5], act[4:2], act[1], act[0],
               exp[8:5], exp[4:2], exp[1], exp[0]);
    end
  endfunction

  function automatic void add(input bit r, input bit v, input int code,
                              input logic [3:0] l, input int sc,
                              input bit lk, input bit st);
    vec_t e;
    e.r    = r;
    e.v    = v;
    e.code = 3'(code);
    e.exp  = {l, 3'(sc), lk, st};
    vecs.push_back(e);
  endfunction

  task automatic step(input bit r, input bit v, input logic [2:0] code);
    @(negedge clk);
    rst              = r;
    bus.answer_valid = v;
    bus.answer_in    = code;
    @(posedge clk);
    cyc++;
    model_edge(r, v, int'(code));
    #1;
    check("model", cyc, outs(), ref_out());
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int         seq[5];
    int         quiet;
    logic [2:0] cur;
    bit         r;
    bit         v;

    rst              = 1'b1;
    bus.answer_valid = 1'b0;
    bus.answer_in    = 3'd0;

    // ---- vector table: basic commit, filter restart, code 0 and invalid code
    add(1'b1, 1'b0, 0, 4'b0000, 0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 2, 4'b0000, 0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 2, 4'b0000, 0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 2, 4'b0010, 2, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) add(1'b0, 1'b0, 0, 4'b0010, 2, 1'b1, 1'b0);
    seq = '{3, 3, 1, 3, 3};
    for (int i = 0; i < 5; i++) add(1'b0, 1'b1, seq[i], 4'b0010, 2, 1'b1, 1'b0);
    add(1'b0, 1'b1, 3, 4'b0100, 3, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) add(1'b0, 1'b0, 0, 4'b0100, 3, 1'b1, 1'b0);
    add(1'b0, 1'b1, 0, 4'b0100, 3, 1'b1, 1'b0);
    add(1'b0, 1'b1, 0, 4'b0100, 3, 1'b1, 1'b0);
    add(1'b0, 1'b1, 0, 4'b1111, 0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) add(1'b0, 1'b0, 0, 4'b1111, 0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 6, 4'b1111, 0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 6, 4'b1111, 0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 6, 4'b0000, 6, 1'b1, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].r, vecs[i].v, vecs[i].code);
      check("vec", i, outs(), vecs[i].exp);
    end

    // ---- hold time: second code confirmed early waits for the hold to expire
    step(1'b1, 1'b0, 3'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 3'd1);
    check("hold_first", 0, outs(), {4'b0001, 3'd1, 1'b1, 1'b0});
    for (int rel = 1; rel <= 8; rel++) begin
      step(1'b0, (rel >= 2 && rel <= 4), (rel >= 2 && rel <= 4) ? 3'd4 : 3'd0);
      if (rel < 8) check("hold_wait", rel, outs(), {4'b0001, 3'd1, 1'b1, 1'b0});
      else         check("hold_commit", rel, outs(), {4'b1000, 3'd4, 1'b1, 1'b0});
    end

    // ---- timeout into STALE, blink, and recovery with the same code
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 3'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 3'd2);
    check("show2", 0, outs(), {4'b0010, 3'd2, 1'b1, 1'b0});
    for (int k = 1; k <= 50; k++) begin
      step(1'b0, 1'b0, 3'd0);
      if (k == 49) check("pre_timeout", k, outs(), {4'b0010, 3'd2, 1'b1, 1'b0});
      if (k == 50) check("timeout", k, outs(), {4'b1111, 3'd2, 1'b0, 1'b1});
    end
    for (int m = 1; m <= 12; m++) begin
      step(1'b0, 1'b0, 3'd0);
      check("blink", m, outs(),
            {(((m / 4) % 2) == 0) ? 4'b1111 : 4'b0000, 3'd2, 1'b0, 1'b1});
    end
    step(1'b0, 1'b1, 3'd2);
    check("stale_s1", 13, outs(), {4'b0000, 3'd2, 1'b0, 1'b1});
    step(1'b0, 1'b1, 3'd2);
    check("stale_s2", 14, outs(), {4'b0000, 3'd2, 1'b0, 1'b1});
    step(1'b0, 1'b1, 3'd2);
    check("stale_recover", 15, outs(), {4'b0010, 3'd2, 1'b1, 1'b0});

    // ---- reset in STALE and mid-confirmation
    for (int i = 0; i < 55; i++) step(1'b0, 1'b0, 3'd0);
    check("stale_again", 0, {3'b000, outs()[5:0]}, {3'b000, 3'd2, 1'b0, 1'b1});
    step(1'b1, 1'b0, 3'd0);
    check("rst_stale", 0, outs(), 9'd0);
    step(1'b0, 1'b1, 3'd1);
    check("after_rst1", 0, outs(), 9'd0);
    step(1'b0, 1'b1, 3'd1);
    check("after_rst2", 0, outs(), 9'd0);
    step(1'b1, 1'b0, 3'd0);
    check("rst_mid", 0, outs(), 9'd0);
    step(1'b0, 1'b1, 3'd1);
    check("mid_s1", 0, outs(), 9'd0);
    step(1'b0, 1'b1, 3'd1);
    check("mid_s2", 0, outs(), 9'd0);
    step(1'b0, 1'b1, 3'd1);
    check("mid_s3", 0, outs(), {4'b0001, 3'd1, 1'b1, 1'b0});

    // ---- randomized traffic against the model
    quiet = 0;
    cur   = 3'd2;
    for (int i = 0; i < 2000; i++) begin
      if (quiet > 0) begin
        quiet--;
        step(1'b0, 1'b0, cur);
      end else begin
        r = ($urandom_range(0, 499) == 0);
        if ($urandom_range(0, 99) == 0) quiet = int'($urandom_range(40, 70));
        if ($urandom_range(0, 9) < 3) cur = 3'($urandom_range(0, 7));
        v = ($urandom_range(0, 3) != 0);
        step(r, v, cur);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
